// File: rtl/zstd_pkg.sv
// Shared Zstandard frame header definitions: magic constant, flag encodings,
// header FSM state type and the Frame_Header_Descriptor layout.
package zstd_pkg;

  localparam logic [31:0] ZSTD_MAGIC    = 32'hFD2FB528;
  localparam int          MAX_HDR_BYTES = 18;

  typedef enum logic [1:0] {
    DID_FLAG_NONE = 2'd0,
    DID_FLAG_1B   = 2'd1,
    DID_FLAG_2B   = 2'd2,
    DID_FLAG_4B   = 2'd3
  } did_flag_e;

  // Flag 0 means "1 byte when single-segment, otherwise absent".
  typedef enum logic [1:0] {
    FCS_FLAG_0B1 = 2'd0,
    FCS_FLAG_2B  = 2'd1,
    FCS_FLAG_4B  = 2'd2,
    FCS_FLAG_8B  = 2'd3
  } fcs_flag_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BUILD = 2'd1;
  localparam state_t ST_EMIT  = 2'd2;

  typedef struct packed {
    logic [1:0] fcs_flag;
    logic       single_segment;
    logic       unused_bit;
    logic       reserved_bit;
    logic       checksum_flag;
    logic [1:0] did_flag;
  } fhd_t;

endpackage

// File: rtl/zstd_hdr_size_enc.sv
// Combinational field sizing for a Zstandard frame header: picks the minimal
// Dictionary_ID and Frame_Content_Size encodings and the total header length.
module zstd_hdr_size_enc
  import zstd_pkg::*;
(
  input  logic        single_segment,
  input  logic        content_size_known,
  input  logic [63:0] content_size,
  input  logic [31:0] dict_id,
  output logic        ss,
  output did_flag_e   did_flag,
  output logic [2:0]  did_len,
  output fcs_flag_e   fcs_flag,
  output logic [3:0]  fcs_len,
  output logic [63:0] fcs_value,
  output logic [4:0]  header_len
);

  logic ge_256;
  logic ge_65792;
  logic ge_4g;

  assign ss       = single_segment && content_size_known;
  assign ge_256   = content_size >= 64'd256;
  assign ge_65792 = content_size >= 64'd65792;
  assign ge_4g    = |content_size[63:32];

  always_comb begin
    did_flag = DID_FLAG_NONE;
    did_len  = 3'd0;
    if (dict_id == 32'd0) begin
      did_flag = DID_FLAG_NONE;
      did_len  = 3'd0;
    end else if (dict_id < 32'd256) begin
      did_flag = DID_FLAG_1B;
      did_len  = 3'd1;
    end else if (dict_id < 32'd65536) begin
      did_flag = DID_FLAG_2B;
      did_len  = 3'd2;
    end else begin
      did_flag = DID_FLAG_4B;
      did_len  = 3'd4;
    end
  end

  // The size thresholds are nested, so the sum of comparisons is a priority pick.
  always_comb begin
    fcs_flag = FCS_FLAG_0B1;
    if (content_size_known) begin
      if (ge_4g)         fcs_flag = FCS_FLAG_8B;
      else if (ge_65792) fcs_flag = FCS_FLAG_4B;
      else if (ge_256)   fcs_flag = FCS_FLAG_2B;
      else               fcs_flag = FCS_FLAG_0B1;
    end
  end

  always_comb begin
    fcs_len = 4'd0;
    case (fcs_flag)
      FCS_FLAG_0B1: fcs_len = ss ? 4'd1 : 4'd0;
      FCS_FLAG_2B:  fcs_len = 4'd2;
      FCS_FLAG_4B:  fcs_len = 4'd4;
      FCS_FLAG_8B:  fcs_len = 4'd8;
      default:      fcs_len = 4'd0;
    endcase
  end

  // The 2-byte form is biased by 256 to extend its reach.
  assign fcs_value  = (fcs_flag == FCS_FLAG_2B) ? (content_size - 64'd256) : content_size;

  assign header_len = 5'd5 + {4'd0, ~ss} + {2'd0, did_len} + {1'b0, fcs_len};

endmodule

// File: rtl/zstd_frame_header_gen.sv
// Zstandard frame header serializer emitting two stream bytes per cycle.
// Optional config rejection is enabled by defining ZSTD_HDR_CHECK_EN.
module zstd_frame_header_gen
  import zstd_pkg::*;
#(
  parameter int MIN_WINDOW_LOG = 10,
  parameter int MAX_WINDOW_LOG = 41
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        single_segment,
  input  logic        checksum_en,
  input  logic [5:0]  window_log,
  input  logic [2:0]  window_mantissa,
  input  logic [31:0] dict_id,
  input  logic        content_size_known,
  input  logic [63:0] content_size,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] data_out,
  output logic        out_single,
  output logic        out_last,
  output logic [4:0]  header_len,
  output logic        cfg_error
);

  localparam int BUF_W = 8 * MAX_HDR_BYTES;

  state_t      state_q, state_d;
  logic        ss_req_q, ss_req_d;
  logic        chk_q, chk_d;
  logic [5:0]  wlog_q, wlog_d;
  logic [2:0]  mant_q, mant_d;
  logic [31:0] dict_q, dict_d;
  logic        known_q, known_d;
  logic [63:0] size_q, size_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  hlen_q, hlen_d;
  logic        cfg_error_q, cfg_error_d;

  logic        enc_ss;
  did_flag_e   enc_did_flag;
  logic [2:0]  enc_did_len;
  fcs_flag_e   enc_fcs_flag;
  logic [3:0]  enc_fcs_len;
  logic [63:0] enc_fcs_value;
  logic [4:0]  enc_len;

  logic [5:0]  wlog_cl;
  logic [4:0]  wd_exp;
  logic [7:0]  wd;
  fhd_t        fhd;
  logic [4:0]  did_pos;
  logic [4:0]  fcs_pos;
  logic [BUF_W-1:0] fill_vec;
  logic        cfg_bad;
  logic        is_last;
  logic [4:0]  idx_p1;
  logic [7:0]  byte_hi;
  logic [7:0]  byte_lo;

  zstd_hdr_size_enc u_size_enc (
    .single_segment     (ss_req_q),
    .content_size_known (known_q),
    .content_size       (size_q),
    .dict_id            (dict_q),
    .ss                 (enc_ss),
    .did_flag           (enc_did_flag),
    .did_len            (enc_did_len),
    .fcs_flag           (enc_fcs_flag),
    .fcs_len            (enc_fcs_len),
    .fcs_value          (enc_fcs_value),
    .header_len         (enc_len)
  );

`ifdef ZSTD_HDR_CHECK_EN
  assign cfg_bad = (single_segment && !content_size_known) ||
                   (int'(window_log) < MIN_WINDOW_LOG) ||
                   (int'(window_log) > MAX_WINDOW_LOG);
`else
  assign cfg_bad = 1'b0;
`endif

  always_comb begin
    wlog_cl = wlog_q;
    if (int'(wlog_q) < MIN_WINDOW_LOG)      wlog_cl = 6'(MIN_WINDOW_LOG);
    else if (int'(wlog_q) > MAX_WINDOW_LOG) wlog_cl = 6'(MAX_WINDOW_LOG);
  end

  assign wd_exp = 5'(wlog_cl - 6'd10);
  assign wd     = {wd_exp, mant_q};

  assign fhd = '{fcs_flag:       enc_fcs_flag,
                 single_segment: enc_ss,
                 unused_bit:     1'b0,
                 reserved_bit:   1'b0,
                 checksum_flag:  chk_q,
                 did_flag:       enc_did_flag};

  // Variable-position fields: Window_Descriptor at 5, then DID, then FCS.
  assign did_pos = 5'd5 + {4'd0, ~enc_ss};
  assign fcs_pos = did_pos + {2'd0, enc_did_len};

  for (genvar gi = 0; gi < MAX_HDR_BYTES; gi++) begin : g_fill
    if (gi < 4) begin : g_magic
      assign fill_vec[8*gi +: 8] = ZSTD_MAGIC[8*gi +: 8];
    end else if (gi == 4) begin : g_fhd
      assign fill_vec[8*gi +: 8] = fhd;
    end else begin : g_var
      localparam logic [4:0] POS = 5'(gi);
      logic [4:0] did_off;
      logic [4:0] fcs_off;
      assign did_off = POS - did_pos;
      assign fcs_off = POS - fcs_pos;
      assign fill_vec[8*gi +: 8] =
          (!enc_ss && POS == 5'd5)                                ? wd :
          (POS >= did_pos && did_off < {2'd0, enc_did_len})       ? dict_q[{did_off[1:0], 3'b000} +: 8] :
          (POS >= fcs_pos && fcs_off < {1'b0, enc_fcs_len})       ? enc_fcs_value[{fcs_off[2:0], 3'b000} +: 8] :
                                                                    8'h00;
    end
  end

  assign is_last = ({1'b0, idx_q} + 6'd2) >= {1'b0, hlen_q};
  assign idx_p1  = idx_q + 5'd1;
  assign byte_hi = buf_q[{idx_q, 3'b000} +: 8];
  assign byte_lo = buf_q[{idx_p1, 3'b000} +: 8];

  always_comb begin
    state_d     = state_q;
    ss_req_d    = ss_req_q;
    chk_d       = chk_q;
    wlog_d      = wlog_q;
    mant_d      = mant_q;
    dict_d      = dict_q;
    known_d     = known_q;
    size_d      = size_q;
    buf_d       = buf_q;
    idx_d       = idx_q;
    hlen_d      = hlen_q;
    cfg_error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          if (cfg_bad) begin
            cfg_error_d = 1'b1;
          end else begin
            ss_req_d = single_segment;
            chk_d    = checksum_en;
            wlog_d   = window_log;
            mant_d   = window_mantissa;
            dict_d   = dict_id;
            known_d  = content_size_known;
            size_d   = content_size;
            state_d  = ST_BUILD;
          end
        end
      end
      ST_BUILD: begin
        buf_d   = fill_vec;
        hlen_d  = enc_len;
        idx_d   = 5'd0;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (is_last) begin
            idx_d   = 5'd0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 5'd2;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ss_req_q    <= 1'b0;
      chk_q       <= 1'b0;
      wlog_q      <= 6'd0;
      mant_q      <= 3'd0;
      dict_q      <= 32'd0;
      known_q     <= 1'b0;
      size_q      <= 64'd0;
      buf_q       <= '0;
      idx_q       <= 5'd0;
      hlen_q      <= 5'd0;
      cfg_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ss_req_q    <= ss_req_d;
      chk_q       <= chk_d;
      wlog_q      <= wlog_d;
      mant_q      <= mant_d;
      dict_q      <= dict_d;
      known_q     <= known_d;
      size_q      <= size_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      hlen_q      <= hlen_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  assign cfg_ready  = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_EMIT);
  assign out_last   = out_valid && is_last;
  assign out_single = out_last && hlen_q[0];
  assign data_out   = out_valid ? {byte_hi, (out_single ? 8'h00 : byte_lo)} : 16'h0000;
  assign header_len = (state_q == ST_BUILD) ? enc_len : hlen_q;
  assign cfg_error  = cfg_error_q;

endmodule

// File: tb/tb_zstd_frame_header_gen.sv
// Directed self-checking bench for zstd_frame_header_gen (default build or
// with ZSTD_HDR_CHECK_EN defined).
module tb_zstd_frame_header_gen;

  logic        clk;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        single_segment;
  logic        checksum_en;
  logic [5:0]  window_log;
  logic [2:0]  window_mantissa;
  logic [31:0] dict_id;
  logic        content_size_known;
  logic [63:0] content_size;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;
  logic        out_single;
  logic        out_last;
  logic [4:0]  header_len;
  logic        cfg_error;

  int checks;
  int failures;
  logic [15:0] exp_q [$];

  zstd_frame_header_gen dut (
    .clk                (clk),
    .reset              (reset),
    .cfg_valid          (cfg_valid),
    .cfg_ready          (cfg_ready),
    .single_segment     (single_segment),
    .checksum_en        (checksum_en),
    .window_log         (window_log),
    .window_mantissa    (window_mantissa),
    .dict_id            (dict_id),
    .content_size_known (content_size_known),
    .content_size       (content_size),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .data_out           (data_out),
    .out_single         (out_single),
    .out_last           (out_last),
    .header_len         (header_len),
    .cfg_error          (cfg_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input logic ss, input logic chk, input logic [5:0] wl, input logic [2:0] mt,
                         input logic [31:0] did, input logic kn, input logic [63:0] sz);
    single_segment     = ss;
    checksum_en        = chk;
    window_log         = wl;
    window_mantissa    = mt;
    dict_id            = did;
    content_size_known = kn;
    content_size       = sz;
    cfg_valid          = 1'b1;
  endtask

  // Offers one config and consumes the header against exp_q.
  // abort_after >= 0 asserts reset once that many words have been accepted.
  task automatic run_hdr(input string nm, input logic ss, input logic chk, input logic [5:0] wl,
                         input logic [2:0] mt, input logic [31:0] did, input logic kn,
                         input logic [63:0] sz, input logic [4:0] exp_len, input bit stall,
                         input int abort_after);
    int k;
    int cyc;
    int nw;
    logic held;
    logic [15:0] held_d;
    nw = exp_q.size();
    @(negedge clk);
    check({nm, "_rdy_idle"}, cfg_ready, 1);
    set_cfg(ss, chk, wl, mt, did, kn, sz);
    @(negedge clk);
    cfg_valid = 1'b0;
    check({nm, "_build_rdy"}, cfg_ready, 0);
    check({nm, "_build_ov"}, out_valid, 0);
    @(negedge clk);
    k = 0;
    cyc = 0;
    held = 1'b0;
    held_d = 16'h0;
    while (k < nw && cyc < 100) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      check({nm, "_ov"}, out_valid, 1);
      check({nm, "_rdy_busy"}, cfg_ready, 0);
      check({nm, "_len"}, header_len, exp_len);
      if (held) check({nm, "_hold"}, data_out, held_d);
      if (out_ready) begin
        check($sformatf("%s_word%0d", nm, k), data_out, exp_q[k]);
        check($sformatf("%s_last%0d", nm, k), out_last, (k == nw - 1));
        check($sformatf("%s_single%0d", nm, k), out_single, (k == nw - 1) && exp_len[0]);
        $display("%s word %0d data=%04h last=%0b single=%0b", nm, k, data_out, out_last, out_single);
        held = 1'b0;
        k++;
      end else begin
        held = 1'b1;
        held_d = data_out;
      end
      @(negedge clk);
      cyc++;
      if (abort_after >= 0 && k == abort_after) begin
        reset = 1'b1;
        out_ready = 1'b0;
        #1;
        check({nm, "_abort_ov"}, out_valid, 0);
        check({nm, "_abort_rdy"}, cfg_ready, 1);
        check({nm, "_abort_len"}, header_len, 0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
    end
    check({nm, "_words_done"}, k, nw);
    out_ready = 1'b0;
    check({nm, "_rdy_after"}, cfg_ready, 1);
    check({nm, "_ov_after"}, out_valid, 0);
  endtask

`ifdef ZSTD_HDR_CHECK_EN
  task automatic run_reject(input string nm, input logic ss, input logic [5:0] wl, input logic kn);
    @(negedge clk);
    set_cfg(ss, 1'b0, wl, 3'd0, 32'd0, kn, 64'd0);
    @(negedge clk);
    cfg_valid = 1'b0;
    check({nm, "_err_pulse"}, cfg_error, 1);
    check({nm, "_err_ov"}, out_valid, 0);
    check({nm, "_err_rdy"}, cfg_ready, 1);
    $display("%s rejected cfg_error=%0b", nm, cfg_error);
    @(negedge clk);
    check({nm, "_err_drop"}, cfg_error, 0);
    for (int i = 0; i < 3; i++) begin
      check({nm, "_err_quiet"}, out_valid, 0);
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    out_ready = 1'b0;
    single_segment = 1'b0;
    checksum_en = 1'b0;
    window_log = 6'd0;
    window_mantissa = 3'd0;
    dict_id = 32'd0;
    content_size_known = 1'b0;
    content_size = 64'd0;
    cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_out_single", out_single, 0);
    check("rst_out_last", out_last, 0);
    check("rst_header_len", header_len, 0);
    check("rst_cfg_error", cfg_error, 0);
    reset = 1'b0;

    exp_q = '{16'h28B5, 16'h2FFD, 16'h2064};
    run_hdr("ss_small", 1'b1, 1'b0, 6'd20, 3'd0, 32'd0, 1'b1, 64'd100, 5'd6, 1'b0, -1);

    exp_q = '{16'h28B5, 16'h2FFD, 16'h4650, 16'h3412, 16'hE802};
    run_hdr("dict2_fcs2", 1'b0, 1'b1, 6'd20, 3'd0, 32'h1234, 1'b1, 64'd1000, 5'd10, 1'b0, -1);

    exp_q = '{16'h28B5, 16'h2FFD, 16'hE3EF, 16'hBEAD, 16'hDE00, 16'h0000, 16'h0001, 16'h0000, 16'h0000};
    run_hdr("dict4_fcs8", 1'b1, 1'b0, 6'd20, 3'd0, 32'hDEADBEEF, 1'b1, 64'h1_0000_0000, 5'd17, 1'b0, -1);

`ifdef ZSTD_HDR_CHECK_EN
    run_reject("unk_ss", 1'b1, 6'd10, 1'b0);
    run_reject("wlog_hi", 1'b0, 6'd45, 1'b0);
`else
    exp_q = '{16'h28B5, 16'h2FFD, 16'h0000};
    run_hdr("unk_ss", 1'b1, 1'b0, 6'd10, 3'd0, 32'd0, 1'b0, 64'd0, 5'd6, 1'b0, -1);
    check("unk_ss_no_err", cfg_error, 0);
    exp_q = '{16'h28B5, 16'h2FFD, 16'h00FD};
    run_hdr("wlog_hi", 1'b0, 1'b0, 6'd45, 3'd5, 32'd0, 1'b0, 64'd0, 5'd6, 1'b0, -1);
    exp_q = '{16'h28B5, 16'h2FFD, 16'h0003};
    run_hdr("wlog_lo", 1'b0, 1'b0, 6'd5, 3'd3, 32'd0, 1'b0, 64'd0, 5'd6, 1'b0, -1);
`endif

    exp_q = '{16'h28B5, 16'h2FFD, 16'h4650, 16'h3412, 16'hE802};
    run_hdr("stall", 1'b0, 1'b1, 6'd20, 3'd0, 32'h1234, 1'b1, 64'd1000, 5'd10, 1'b1, -1);

    run_hdr("abort", 1'b0, 1'b1, 6'd20, 3'd0, 32'h1234, 1'b1, 64'd1000, 5'd10, 1'b0, 2);

    exp_q = '{16'h28B5, 16'h2FFD, 16'h2064};
    run_hdr("post_abort", 1'b1, 1'b0, 6'd20, 3'd0, 32'd0, 1'b1, 64'd100, 5'd6, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
